// File: rtl/interc_sw_evt_pkg.sv
// Shared types for the cluster software-event scheduler: one buffered trigger
// is an event index plus the mask of cores it targets.
package interc_sw_evt_pkg;
  localparam int PKG_NB_CORES = 8;
  localparam int STATUS_CNT_W = 6;

  typedef struct packed {
    logic [2:0]              evt;
    logic [PKG_NB_CORES-1:0] mask;
  } sw_evt_trig_t;
endpackage

// File: rtl/sw_evt_trig_fifo.sv
// Synchronous trigger FIFO; pointers and count are reset, storage is not.
// Caller must not push when full nor pop when empty.
module sw_evt_trig_fifo
  import interc_sw_evt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  sw_evt_trig_t             push_data_i,
  input  logic                     pop_i,
  output sw_evt_trig_t             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  sw_evt_trig_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_data_i;
  end
endmodule

// File: rtl/interc_sw_evt_sched.sv
// Round-robin shared access to the software-event trigger path; granted writes
// queue in a FIFO that drains into one-cycle per-core event pulses.
module interc_sw_evt_sched
  import interc_sw_evt_pkg::*;
#(
  parameter int NB_REQ     = 4,
  parameter int NB_CORES   = 8,
  parameter int NB_SW_EVT  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NB_REQ-1:0]             req_i,
  input  logic [NB_REQ-1:0]             we_n_i,
  input  logic [NB_REQ*32-1:0]          add_i,
  input  logic [NB_REQ*32-1:0]          wdata_i,
  output logic [NB_REQ-1:0]             gnt_o,
  output logic [NB_REQ-1:0]             r_valid_o,
  output logic [31:0]                   r_rdata_o,
  input  logic                          evt_stall_i,
  output logic [NB_CORES*NB_SW_EVT-1:0] sw_events_o
);
  localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PW-1:0]       r_rr_ptr;
  logic [NB_REQ-1:0]   w_elig;
  logic [NB_REQ-1:0]   w_gnt;
  logic [PW-1:0]       w_gnt_idx;
  logic                w_found;
  logic                w_sel_we_n;
  logic [31:0]         w_sel_add;
  logic [31:0]         w_sel_wdata;
  logic [NB_CORES-1:0] w_wmask;
  logic                w_push;
  logic                w_pop;
  sw_evt_trig_t        w_push_data;
  sw_evt_trig_t        w_head;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [31:0]         w_status;
  logic                w_unused;

  // Full is taken before any pop this cycle, so a pop never lets a write through.
  assign w_elig = req_i & (we_n_i | {NB_REQ{~w_full}});

  always_comb begin
    int idx;
    idx       = 0;
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    for (int o = 0; o < NB_REQ; o++) begin
      idx = int'(r_rr_ptr) + o;
      if (idx >= NB_REQ) idx = idx - NB_REQ;
      if (!w_found && w_elig[idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = PW'(idx);
      end
    end
    if (w_found && !rst_i) w_gnt[w_gnt_idx] = 1'b1;
  end

  assign gnt_o       = w_gnt;
  assign w_sel_we_n  = we_n_i[w_gnt_idx];
  assign w_sel_add   = add_i[w_gnt_idx*32 +: 32];
  assign w_sel_wdata = wdata_i[w_gnt_idx*32 +: 32];
  assign w_wmask     = w_sel_wdata[NB_CORES-1:0];
  assign w_push      = w_found & ~rst_i & ~w_sel_we_n;
  assign w_pop       = ~w_empty & ~evt_stall_i & ~rst_i;

  always_comb begin
    w_push_data.evt  = w_sel_add[4:2] & 3'(NB_SW_EVT-1);
    w_push_data.mask = PKG_NB_CORES'((w_wmask == '0) ? {NB_CORES{1'b1}} : w_wmask);
  end

  assign w_status = {24'b0, w_full, w_empty, STATUS_CNT_W'(w_count)};

  sw_evt_trig_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_push),
    .push_data_i (w_push_data),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr  <= '0;
      r_valid_o <= '0;
      r_rdata_o <= '0;
    end else begin
      if (w_found) r_rr_ptr <= (int'(w_gnt_idx) == NB_REQ-1) ? '0 : w_gnt_idx + PW'(1);
      r_valid_o <= w_gnt;
      r_rdata_o <= (w_found && w_sel_we_n) ? w_status : 32'b0;
    end
  end

  // Pulses are decoded straight from the head in the cycle it is popped.
  always_comb begin
    sw_events_o = '0;
    if (w_pop) begin
      for (int c = 0; c < NB_CORES; c++) begin
        for (int e = 0; e < NB_SW_EVT; e++) begin
          sw_events_o[c*NB_SW_EVT+e] = (w_head.evt == 3'(e)) & w_head.mask[c];
        end
      end
    end
  end

  assign w_unused = ^{add_i, wdata_i, w_head.mask};
endmodule
